// File: rtl/xbar_sched_pkg.sv
// xbar_sched_pkg: beat field positions, port count and per-output FSM encoding for the crossbar scheduler
package xbar_sched_pkg;
  localparam int NPORT = 4;
  localparam int WIDTH = 15;
  localparam int VLD = 14;
  localparam int LAST = 13;
  localparam int DEST_HI = 12;
  localparam int DEST_LO = 11;
  localparam int SRC_HI = 9;
  localparam int SRC_LO = 8;
  localparam int PLD_HI = 7;
  localparam int PLD_LO = 0;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;
endpackage

// File: rtl/xbar_sched_rr_arb4.sv
// rr_arb4: combinational 4-way round-robin pick, first requester at or above ptr wins
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);
  logic [3:0] rot;
  logic [1:0] k;
  assign rot = ptr == 2'd0 ? req :
               ptr == 2'd1 ? {req[0], req[3:1]} :
               ptr == 2'd2 ? {req[1:0], req[3:2]} : {req[2:0], req[3]};
  assign k = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign idx = ptr + k;
  assign gnt = |req ? 4'b0001 << idx : 4'b0000;
endmodule

// File: rtl/xbar_sched.sv
// xbar_sched: round-robin 4x4 crossbar scheduler with packet locking and registered output stage
module xbar_sched
  import xbar_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] iport0,
  input  logic [WIDTH-1:0] iport1,
  input  logic [WIDTH-1:0] iport2,
  input  logic [WIDTH-1:0] iport3,
  output logic [NPORT-1:0] in_ready,
  output logic [WIDTH-1:0] oport0,
  output logic [WIDTH-1:0] oport1,
  output logic [WIDTH-1:0] oport2,
  output logic [WIDTH-1:0] oport3,
  input  logic [NPORT-1:0] out_ready,
  output logic [NPORT-1:0] busy,
  output logic             proto_err
);
  logic [NPORT-1:0][WIDTH-1:0] ib, ob, ob_nx;
  logic [NPORT-1:0][NPORT-1:0] req, gnt;
  logic [NPORT-1:0][1:0] idx, ptr, ptr_nx, own, own_nx;
  logic [NPORT-1:0] st, st_nx, lkin, free, take;
  logic perr;
  assign ib = {iport3, iport2, iport1, iport0};
  assign {oport3, oport2, oport1, oport0} = ob;
  assign busy = st;
  // an input owning a locked output is barred from every other output
  always_comb begin
    lkin = '0;
    perr = 1'b0;
    for (int o = 0; o < NPORT; o++)
      if (st[o] == ST_LOCK) begin
        lkin[own[o]] = 1'b1;
        perr = perr | (ib[own[o]][VLD] & (ib[own[o]][DEST_HI:DEST_LO] != 2'(o)));
      end
  end
  always_comb begin
    req = '0;
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        req[o][i] = ib[i][VLD] & (ib[i][DEST_HI:DEST_LO] == 2'(o)) &
                    (st[o] == ST_LOCK ? own[o] == 2'(i) : !lkin[i]);
  end
  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb4 u_arb (.req(req[o]), .ptr(ptr[o]), .gnt(gnt[o]), .idx(idx[o]));
  end
  always_comb begin
    in_ready = '0;
    free = '0;
    take = '0;
    st_nx = st;
    own_nx = own;
    ptr_nx = ptr;
    ob_nx = ob;
    for (int o = 0; o < NPORT; o++) begin
      free[o] = !ob[o][VLD] | out_ready[o];
      take[o] = free[o] & |req[o];
      in_ready = in_ready | (take[o] ? gnt[o] : 4'b0000);
      st_nx[o] = take[o] ? (ib[idx[o]][LAST] ? ST_IDLE : ST_LOCK) : st[o];
      own_nx[o] = take[o] & !ib[idx[o]][LAST] ? idx[o] : own[o];
      ptr_nx[o] = take[o] & ib[idx[o]][LAST] ? idx[o] + 2'd1 : ptr[o];
      ob_nx[o] = take[o] ? ib[idx[o]] : out_ready[o] ? '0 : ob[o];
    end
    in_ready = in_ready & {NPORT{rst}};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= '0;
      own <= '0;
      ptr <= '0;
      ob <= '0;
      proto_err <= 1'b0;
    end else begin
      st <= st_nx;
      own <= own_nx;
      ptr <= ptr_nx;
      ob <= ob_nx;
      proto_err <= proto_err | perr;
    end
endmodule

// File: tb/tb_xbar_sched.sv
// tb_xbar_sched: directed stimulus with per-output expected-beat queues checked by a decoupled monitor
module tb_xbar_sched;
  logic clk = 0, rst = 0;
  logic [14:0] ip[4], op[4];
  logic [3:0] in_ready, ordy, busy;
  logic proto_err;
  logic [14:0] exq[4][$];
  int ncmp = 0, nerr = 0;

  xbar_sched dut (
    .clk(clk), .rst(rst),
    .iport0(ip[0]), .iport1(ip[1]), .iport2(ip[2]), .iport3(ip[3]),
    .in_ready(in_ready),
    .oport0(op[0]), .oport1(op[1]), .oport2(op[2]), .oport3(op[3]),
    .out_ready(ordy), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [14:0] mk(input logic l, input logic [1:0] d, input logic [1:0] s, input logic [7:0] p);
    return {1'b1, l, d, 1'b0, s, p};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // one cycle: check handshake/status mid-cycle, record accepted beats, advance past the edge
  task automatic step(input logic [3:0] er, input logic [3:0] eb, input logic ep);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("busy", 32'(busy), 32'(eb));
    chk("proto_err", 32'(proto_err), 32'(ep));
    for (int i = 0; i < 4; i++)
      if (er[i]) exq[ip[i][12:11]].push_back(ip[i]);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst)
      for (int o = 0; o < 4; o++)
        if (op[o][14] && ordy[o]) begin
          if (exq[o].size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL unexpected_beat oport%0d: got %h expected none", o, op[o]);
          end else chk($sformatf("oport%0d_beat", o), 32'(op[o]), 32'(exq[o].pop_front()));
        end

  initial begin
    for (int i = 0; i < 4; i++) ip[i] = '0;
    ordy = 4'hF;
    ip[0] = mk(1, 2'd1, 2'd0, 8'h99);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    for (int o = 0; o < 4; o++) chk("rst_oport", 32'(op[o]), 0);
    ip[0] = '0;
    @(posedge clk);
    #1 rst = 1;
    // single beat
    ip[2] = mk(1, 2'd3, 2'd2, 8'hA5);
    step(4'b0100, 0, 0);
    chk("oport3_load", 32'(op[3]), 32'(mk(1, 2'd3, 2'd2, 8'hA5)));
    ip[2] = '0;
    step(4'b0000, 0, 0);
    chk("oport3_clear", 32'(op[3]), 0);
    // fairness on output 1
    for (int i = 0; i < 4; i++) ip[i] = mk(1, 2'd1, 2'(i), 8'h10 + 8'(i));
    step(4'b0001, 0, 0);
    step(4'b0010, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b0001, 0, 0);
    for (int i = 0; i < 4; i++) ip[i] = '0;
    step(4'b0000, 0, 0);
    // lock on output 2
    ip[0] = mk(0, 2'd2, 2'd0, 8'h01);
    ip[1] = mk(1, 2'd2, 2'd1, 8'h11);
    step(4'b0001, 4'b0000, 0);
    ip[0] = mk(0, 2'd2, 2'd0, 8'h02);
    step(4'b0001, 4'b0100, 0);
    ip[0] = mk(1, 2'd2, 2'd0, 8'h03);
    step(4'b0001, 4'b0100, 0);
    ip[0] = '0;
    step(4'b0010, 4'b0000, 0);
    ip[1] = '0;
    step(4'b0000, 0, 0);
    // backpressure on output 0
    ip[2] = mk(1, 2'd0, 2'd2, 8'h55);
    step(4'b0100, 0, 0);
    ip[2] = '0;
    ip[3] = mk(1, 2'd0, 2'd3, 8'h66);
    ordy = 4'b1110;
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    chk("oport0_hold", 32'(op[0]), 32'(mk(1, 2'd0, 2'd2, 8'h55)));
    ordy = 4'hF;
    step(4'b1000, 0, 0);
    chk("oport0_update", 32'(op[0]), 32'(mk(1, 2'd0, 2'd3, 8'h66)));
    ip[3] = '0;
    step(4'b0000, 0, 0);
    // protocol error, then asynchronous reset mid-cycle
    ip[1] = mk(0, 2'd0, 2'd1, 8'h21);
    step(4'b0010, 4'b0000, 0);
    ip[1] = mk(1, 2'd2, 2'd1, 8'h22);
    ip[3] = mk(1, 2'd3, 2'd3, 8'h77);
    step(4'b1000, 4'b0001, 0);
    ip[3] = '0;
    chk("perr_set", 32'(proto_err), 1);
    chk("perr_busy", 32'(busy), 32'(4'b0001));
    chk("perr_oport3", 32'(op[3]), 32'(mk(1, 2'd3, 2'd3, 8'h77)));
    #2 rst = 0;
    #1;
    chk("arst_oport3", 32'(op[3]), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_proto_err", 32'(proto_err), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    for (int o = 0; o < 4; o++) exq[o].delete();
    for (int i = 0; i < 4; i++) ip[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    // pointers restart at 0 after reset
    ip[0] = mk(1, 2'd1, 2'd0, 8'h31);
    ip[1] = mk(1, 2'd1, 2'd1, 8'h41);
    step(4'b0001, 0, 0);
    step(4'b0010, 0, 0);
    ip[0] = '0;
    ip[1] = '0;
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    for (int o = 0; o < 4; o++) chk($sformatf("queue%0d_drained", o), 32'(exq[o].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
